anim_sequencer: RTL and testbench
=================================

// Module: anim_sequencer
// PURPOSE
//  Sequences up to two bouncing objects (paddle/ball movers) for the VGA demo.
//  - Turns the per-frame end pulse into the animation strobe and enable the movers consume.
//  - Runs the start/pause/hit flow.
//  - Detects bounding-box overlap between objects A and B, counts hits, and re-homes both objects after each hit.
//  - Sits between the VGA timing generator and the object movers.
// PARAMETERS
//  STB_DIV      1    frames per animation step (1..255); strobe every STB_DIV-th frame
//  HOLD_FRAMES  60   frames spent in HIT before objects are re-homed (1..255)
//  SCORE_W      8    width of hit counter
// PORTS
//  in_clock       in   1        system clock
//  in_reset       in   1        asynchronous, active-high reset
//  in_frame_end   in   1        1-cycle pulse, once per frame (end of active video)
//  in_start       in   1        1-cycle pulse: start / resume
//  in_pause       in   1        1-cycle pulse: toggle RUN<->PAUSE
//  in_a_x1..y2    in   12 each  object A edges (left, right, top, bottom), unsigned
//  in_b_x1..y2    in   12 each  object B edges, unsigned
//  out_ani_stb    out  1        1-cycle animation strobe to movers
//  out_animate    out  1        high while RUN
//  out_obj_reset  out  1        reset to movers (level in IDLE, 1-cycle pulse at end of HIT)
//  out_state      out  2        0=IDLE 1=RUN 2=PAUSE 3=HIT
//  out_hits       out  SCORE_W  collision count, saturating
//  out_hit_flash  out  1        high while HIT (for display colour)
// BEHAVIOUR
//  Reset values
//   - state=IDLE, out_obj_reset=1, every other output 0, div_cnt=0, hold_cnt=0.
//   - All outputs are registered and valid the cycle after the causing input.
//  IDLE
//   - out_obj_reset held 1.
//   - in_start -> RUN; div_cnt<=0; out_obj_reset<=0.
//  RUN
//   - out_animate=1.
//   - On in_frame_end: div_cnt increments. At div_cnt==STB_DIV-1: out_ani_stb=1 for exactly one cycle, div_cnt<=0.
//   - in_pause -> PAUSE.
//  PAUSE
//   - out_animate=0; div_cnt frozen; frame pulses ignored.
//   - in_pause or in_start -> RUN; div_cnt is kept.
//  Collision
//   - overlap = (a_x1<=b_x2)&(b_x1<=a_x2)&(a_y1<=b_y2)&(b_y1<=a_y2); unsigned compare, inclusive.
//   - Sampled only on an in_frame_end cycle while in RUN.
//   - If overlap: -> HIT; out_hits+1, saturating at all-ones; hold_cnt<=0; no strobe that frame.
//  HIT
//   - out_animate=0; out_hit_flash=1; in_start and in_pause ignored.
//   - Each in_frame_end increments hold_cnt.
//   - At hold_cnt==HOLD_FRAMES-1: out_obj_reset=1 for one cycle, -> RUN, div_cnt<=0.
//  Priority in RUN, same cycle
//   - in_pause beats collision: go to PAUSE, no hit counted.
//   - Collision beats strobe.
//   - in_start in RUN: no effect.
//  Other rules
//   - STB_DIV=1: strobe on every frame.
//   - in_reset asserted mid-operation: immediate return to reset values; out_hits cleared.
// TESTING
//  1. Reset, then in_start, then 6 frame pulses with STB_DIV=2 -> 3 strobes, one per 2nd frame; out_animate=1 from cycle after start.
//  2. RUN, then in_pause, then 4 frames, then in_pause -> no strobes during PAUSE; div_cnt resumes from its held value.
//  3. A=(100,120,200,380), B=(118,130,300,310), frame_end in RUN -> HIT, out_hits=1, out_hit_flash=1, no strobe.
//  4. HOLD_FRAMES=3 in HIT, then 3 frame pulses -> 1-cycle out_obj_reset after the 3rd pulse, then RUN.
//  5. A=(100,120,...), B x1=121 (edges just apart), frame_end -> no hit.
//  6. SCORE_W=2, force 5 hits -> out_hits saturates at 3.
//  7. in_pause and colliding frame_end in the same cycle -> PAUSE, out_hits unchanged.
//  8. in_reset asserted mid-HIT -> IDLE, out_hits=0, out_obj_reset=1.

Source files
------------

// File: rtl/anim_sequencer.sv
// Frame-driven animation sequencer: derives mover strobes from frame pulses,
// runs the IDLE/RUN/PAUSE/HIT flow and scores A/B bounding-box collisions.
module anim_sequencer #(
    parameter int STB_DIV     = 1,
    parameter int HOLD_FRAMES = 60,
    parameter int SCORE_W     = 8
) (
    input  logic               in_clock,
    input  logic               in_reset,
    input  logic               in_frame_end,
    input  logic               in_start,
    input  logic               in_pause,
    input  logic [11:0]        in_a_x1,
    input  logic [11:0]        in_a_x2,
    input  logic [11:0]        in_a_y1,
    input  logic [11:0]        in_a_y2,
    input  logic [11:0]        in_b_x1,
    input  logic [11:0]        in_b_x2,
    input  logic [11:0]        in_b_y1,
    input  logic [11:0]        in_b_y2,
    output logic               out_ani_stb,
    output logic               out_animate,
    output logic               out_obj_reset,
    output logic [1:0]         out_state,
    output logic [SCORE_W-1:0] out_hits,
    output logic               out_hit_flash
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HIT   = 2'd3
    } state_t;

    localparam logic [7:0] STB_LAST  = 8'(STB_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t             state_q, state_d;
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [SCORE_W-1:0] hits_q, hits_d;
    logic               ani_stb_q, ani_stb_d;
    logic               animate_q, animate_d;
    logic               obj_reset_q, obj_reset_d;
    logic               hit_flash_q, hit_flash_d;
    logic               overlap;

    // Inclusive unsigned box test: touching edges count as a hit.
    assign overlap = (in_a_x1 <= in_b_x2) && (in_b_x1 <= in_a_x2) &&
                     (in_a_y1 <= in_b_y2) && (in_b_y1 <= in_a_y2);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        hits_d      = hits_q;
        ani_stb_d   = 1'b0;
        obj_reset_d = 1'b0;

        case (state_q)
            IDLE: begin
                obj_reset_d = 1'b1;
                if (in_start) begin
                    state_d     = RUN;
                    div_cnt_d   = 8'd0;
                    obj_reset_d = 1'b0;
                end
            end
            RUN: begin
                // Pause outranks a colliding frame; a collision swallows that frame's strobe.
                if (in_pause) begin
                    state_d = PAUSE;
                end else if (in_frame_end) begin
                    if (overlap) begin
                        state_d    = HIT;
                        hold_cnt_d = 8'd0;
                        if (hits_q != {SCORE_W{1'b1}}) begin
                            hits_d = hits_q + SCORE_W'(1);
                        end
                    end else if (div_cnt_q == STB_LAST) begin
                        ani_stb_d = 1'b1;
                        div_cnt_d = 8'd0;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
            end
            PAUSE: begin
                if (in_pause || in_start) begin
                    state_d = RUN;
                end
            end
            HIT: begin
                if (in_frame_end) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d     = RUN;
                        obj_reset_d = 1'b1;
                        div_cnt_d   = 8'd0;
                        hold_cnt_d  = 8'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        animate_d   = (state_d == RUN);
        hit_flash_d = (state_d == HIT);
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= 8'd0;
            hold_cnt_q  <= 8'd0;
            hits_q      <= '0;
            ani_stb_q   <= 1'b0;
            animate_q   <= 1'b0;
            obj_reset_q <= 1'b1;
            hit_flash_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            hits_q      <= hits_d;
            ani_stb_q   <= ani_stb_d;
            animate_q   <= animate_d;
            obj_reset_q <= obj_reset_d;
            hit_flash_q <= hit_flash_d;
        end
    end

    assign out_state     = state_q;
    assign out_ani_stb   = ani_stb_q;
    assign out_animate   = animate_q;
    assign out_obj_reset = obj_reset_q;
    assign out_hits      = hits_q;
    assign out_hit_flash = hit_flash_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with STB_DIV=2, HOLD_FRAMES=3, SCORE_W=2.
module tb_anim_sequencer;

    logic        in_clock = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_frame_end = 1'b0;
    logic        in_start = 1'b0;
    logic        in_pause = 1'b0;
    logic [11:0] in_a_x1, in_a_x2, in_a_y1, in_a_y2;
    logic [11:0] in_b_x1, in_b_x2, in_b_y1, in_b_y2;
    logic        out_ani_stb, out_animate, out_obj_reset, out_hit_flash;
    logic [1:0]  out_state;
    logic [1:0]  out_hits;

    int total = 0;
    int bad = 0;
    int exp_hits;
    int stb_count;

    anim_sequencer #(.STB_DIV(2), .HOLD_FRAMES(3), .SCORE_W(2)) dut (
        .in_clock(in_clock), .in_reset(in_reset),
        .in_frame_end(in_frame_end), .in_start(in_start), .in_pause(in_pause),
        .in_a_x1(in_a_x1), .in_a_x2(in_a_x2), .in_a_y1(in_a_y1), .in_a_y2(in_a_y2),
        .in_b_x1(in_b_x1), .in_b_x2(in_b_x2), .in_b_y1(in_b_y1), .in_b_y2(in_b_y2),
        .out_ani_stb(out_ani_stb), .out_animate(out_animate),
        .out_obj_reset(out_obj_reset), .out_state(out_state),
        .out_hits(out_hits), .out_hit_flash(out_hit_flash)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle pulses on the chosen inputs; returns at the negedge after the capturing posedge.
    task automatic pulse(input logic f, input logic s, input logic p);
        @(negedge in_clock);
        in_frame_end = f;
        in_start     = s;
        in_pause     = p;
        @(negedge in_clock);
        in_frame_end = 1'b0;
        in_start     = 1'b0;
        in_pause     = 1'b0;
    endtask

    task automatic set_apart();
        in_a_x1 = 12'd0;   in_a_x2 = 12'd10;  in_a_y1 = 12'd0;   in_a_y2 = 12'd10;
        in_b_x1 = 12'd100; in_b_x2 = 12'd110; in_b_y1 = 12'd100; in_b_y2 = 12'd110;
    endtask

    task automatic set_boxes(input logic [11:0] bx1, input logic [11:0] bx2);
        in_a_x1 = 12'd100; in_a_x2 = 12'd120; in_a_y1 = 12'd200; in_a_y2 = 12'd380;
        in_b_x1 = bx1;     in_b_x2 = bx2;     in_b_y1 = 12'd300; in_b_y2 = 12'd310;
    endtask

    initial begin
        set_apart();
        repeat (3) @(negedge in_clock);
        check("rst_state", 32'(out_state), 32'd0);
        check("rst_obj_reset", 32'(out_obj_reset), 32'd1);
        check("rst_animate", 32'(out_animate), 32'd0);
        check("rst_stb", 32'(out_ani_stb), 32'd0);
        check("rst_hits", 32'(out_hits), 32'd0);
        check("rst_flash", 32'(out_hit_flash), 32'd0);
        in_reset = 1'b0;
        pulse(0, 0, 0);
        check("idle_obj_reset", 32'(out_obj_reset), 32'd1);

        // Start, then six frames: strobe on every second frame.
        pulse(0, 1, 0);
        check("start_state", 32'(out_state), 32'd1);
        check("start_animate", 32'(out_animate), 32'd1);
        check("start_obj_reset", 32'(out_obj_reset), 32'd0);
        stb_count = 0;
        for (int i = 1; i <= 6; i++) begin
            pulse(1, 0, 0);
            check($sformatf("run_stb_f%0d", i), 32'(out_ani_stb), 32'((i % 2) == 0));
            if (out_ani_stb) stb_count++;
            @(negedge in_clock);
            check($sformatf("run_stb_gap%0d", i), 32'(out_ani_stb), 32'd0);
        end
        check("run_stb_count", 32'(stb_count), 32'd3);

        // Start while running does nothing.
        pulse(0, 1, 0);
        check("run_start_noop", 32'(out_state), 32'd1);

        // Pause with div_cnt=1 held across ignored frames.
        pulse(1, 0, 0);
        check("pre_pause_stb", 32'(out_ani_stb), 32'd0);
        pulse(0, 0, 1);
        check("pause_state", 32'(out_state), 32'd2);
        check("pause_animate", 32'(out_animate), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0, 0);
            check($sformatf("pause_stb_f%0d", i), 32'(out_ani_stb), 32'd0);
        end
        pulse(0, 0, 1);
        check("resume_state", 32'(out_state), 32'd1);
        pulse(1, 0, 0);
        check("resume_held_div_stb", 32'(out_ani_stb), 32'd1);

        // Collision on a frame that would otherwise strobe.
        pulse(1, 0, 0);
        check("pre_hit_stb", 32'(out_ani_stb), 32'd0);
        set_boxes(12'd118, 12'd130);
        pulse(1, 0, 0);
        check("hit_state", 32'(out_state), 32'd3);
        check("hit_hits", 32'(out_hits), 32'd1);
        check("hit_flash", 32'(out_hit_flash), 32'd1);
        check("hit_no_stb", 32'(out_ani_stb), 32'd0);
        check("hit_animate", 32'(out_animate), 32'd0);

        // HIT ignores start/pause, then re-homes after the third frame.
        pulse(0, 1, 1);
        check("hit_ignores_ctl", 32'(out_state), 32'd3);
        set_apart();
        pulse(1, 0, 0);
        check("hold_f1_state", 32'(out_state), 32'd3);
        pulse(1, 0, 0);
        check("hold_f2_obj_reset", 32'(out_obj_reset), 32'd0);
        pulse(1, 0, 0);
        check("hold_f3_obj_reset", 32'(out_obj_reset), 32'd1);
        check("hold_f3_state", 32'(out_state), 32'd1);
        check("hold_f3_flash", 32'(out_hit_flash), 32'd0);
        @(negedge in_clock);
        check("hold_obj_reset_pulse", 32'(out_obj_reset), 32'd0);
        pulse(1, 0, 0);
        check("rehome_div0_stb", 32'(out_ani_stb), 32'd0);
        pulse(1, 0, 0);
        check("rehome_div1_stb", 32'(out_ani_stb), 32'd1);

        // Edges one apart: no hit.
        set_boxes(12'd121, 12'd130);
        pulse(1, 0, 0);
        check("apart_state", 32'(out_state), 32'd1);
        check("apart_hits", 32'(out_hits), 32'd1);

        // Pause and colliding frame together: pause wins.
        set_boxes(12'd120, 12'd130);
        pulse(1, 0, 1);
        check("pause_vs_hit_state", 32'(out_state), 32'd2);
        check("pause_vs_hit_hits", 32'(out_hits), 32'd1);
        pulse(0, 1, 0);
        check("start_resume_state", 32'(out_state), 32'd1);

        // Touching edges collide; four more hits saturate a 2-bit score at 3.
        exp_hits = 1;
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0, 0);
            exp_hits = (exp_hits < 3) ? exp_hits + 1 : 3;
            check($sformatf("sat_hit%0d_state", i), 32'(out_state), 32'd3);
            check($sformatf("sat_hit%0d_hits", i), 32'(out_hits), 32'(exp_hits));
            repeat (3) pulse(1, 0, 0);
            check($sformatf("sat_hit%0d_back", i), 32'(out_state), 32'd1);
        end

        // Asynchronous reset in the middle of HIT.
        pulse(1, 0, 0);
        check("mid_hit_state", 32'(out_state), 32'd3);
        pulse(1, 0, 0);
        in_reset = 1'b1;
        #1;
        check("async_rst_state", 32'(out_state), 32'd0);
        check("async_rst_hits", 32'(out_hits), 32'd0);
        check("async_rst_obj_reset", 32'(out_obj_reset), 32'd1);
        check("async_rst_flash", 32'(out_hit_flash), 32'd0);
        @(negedge in_clock);
        in_reset = 1'b0;
        pulse(0, 0, 0);
        check("post_rst_state", 32'(out_state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
